// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared 7-segment constants for the display blocks
package display_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // seg[DP_BIT] is the decimal point; it marks the hours/minutes boundary
  localparam int DP_BIT   = 7;
  localparam int DP_DIGIT = 2;

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - BCD nibble to active-high 7-segment pattern {g..a}
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - multiplexed 7-segment scan with blink and alarm compare
module display_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] current_time,
  input  logic [4*NUM_DIGITS-1:0] alarm_time,
  input  logic [4*NUM_DIGITS-1:0] key_time,
  input  logic                    show_new_time,
  input  logic                    show_a,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    alarm_enable,
  input  logic                    stop_alarm,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    sound
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FRM_W = $clog2(BLINK_DIV + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] DP_IDX   = IDX_W'(DP_DIGIT);
  localparam bit               HAS_DP   = (NUM_DIGITS >= 3);

  logic [CNT_W-1:0]      r_scan_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [FRM_W-1:0]      r_frame_cnt;
  logic                  r_blink_phase;
  logic                  r_match;
  logic                  r_match_d;
  logic                  r_sound;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_digit_en;

  logic [4*NUM_DIGITS-1:0] w_src;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg7;
  logic                    w_dp;
  logic                    w_blank;
  logic [7:0]              w_seg_next;
  logic                    w_term;
  logic                    w_wrap;
  logic                    w_match;
  logic                    w_rise;

  always_comb begin
    w_src = current_time;
    if (show_new_time)
      w_src = key_time;
    else if (show_a)
      w_src = alarm_time;
  end

  assign w_nibble = w_src[{r_idx, 2'b00} +: 4];

  seg7_encode u_enc (
    .i_nibble (w_nibble),
    .o_seg    (w_seg7)
  );

  assign w_dp       = HAS_DP && (r_idx == DP_IDX);
  assign w_blank    = show_new_time & r_blink_phase & blink_mask[r_idx];
  assign w_seg_next = w_blank ? 8'h00 : ({1'b0, w_seg7} | (8'(w_dp) << DP_BIT));
  assign w_term     = (r_scan_cnt == LAST_CNT);
  assign w_wrap     = w_term && (r_idx == LAST_IDX);
  assign w_match    = (current_time == alarm_time);
  assign w_rise     = r_match & ~r_match_d;

  // Frame counting runs continuously so the blink phase is stable when entry mode begins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_scan_cnt    <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_scan_cnt <= w_term ? '0 : r_scan_cnt + 1'b1;
      if (w_term)
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      if (w_wrap) begin
        if (r_frame_cnt == LAST_FRM) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_seg      <= 8'h00;
      r_digit_en <= '0;
    end else begin
      r_seg      <= w_seg_next;
      r_digit_en <= NUM_DIGITS'(1) << r_idx;
    end
  end

  // Match history resets high so a match already present at release is not an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_match   <= 1'b1;
      r_match_d <= 1'b1;
      r_sound   <= 1'b0;
    end else begin
      r_match   <= w_match;
      r_match_d <= r_match;
      if (stop_alarm || !alarm_enable)
        r_sound <= 1'b0;
      else if (w_rise)
        r_sound <= 1'b1;
    end
  end

  assign seg      = r_seg;
  assign digit_en = r_digit_en;
  assign sound    = r_sound;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - scoreboard bench for display_scan_driver
module tb_display_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [4*ND-1:0] current_time;
  logic [4*ND-1:0] alarm_time;
  logic [4*ND-1:0] key_time;
  logic            show_new_time;
  logic            show_a;
  logic [ND-1:0]   blink_mask;
  logic            alarm_enable;
  logic            stop_alarm;
  logic [7:0]      seg;
  logic [ND-1:0]   digit_en;
  logic            sound;

  always #5 clock = ~clock;

  display_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .current_time  (current_time),
    .alarm_time    (alarm_time),
    .key_time      (key_time),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .blink_mask    (blink_mask),
    .alarm_enable  (alarm_enable),
    .stop_alarm    (stop_alarm),
    .seg           (seg),
    .digit_en      (digit_en),
    .sound         (sound)
  );

  typedef struct packed {
    logic [7:0]    seg;
    logic [ND-1:0] en;
    logic          snd;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Reference model: position in the scan follows from the edge count since release
  int              m_k;
  int              m_cyc;
  int              m_idx;
  int              m_frame;
  bit              m_phase;
  logic [4*ND-1:0] m_src;
  int              m_nib;
  bit              m_hist[$];
  bit              m_snd;
  exp_t            m_e;

  always @(posedge clock) begin
    if (!reset) begin
      m_k    = 0;
      m_hist = '{1'b1, 1'b1};
      m_snd  = 1'b0;
      m_e    = '0;
    end else begin
      m_k++;
      m_cyc   = m_k - 1;
      m_idx   = (m_cyc / SD) % ND;
      m_frame = m_cyc / (SD * ND);
      m_phase = ((m_frame / BD) % 2) == 1;
      m_src   = show_new_time ? key_time : (show_a ? alarm_time : current_time);
      m_nib   = int'(m_src[m_idx*4 +: 4]);
      m_e.seg = (m_nib < 10) ? seg_tab[m_nib] : 8'h00;
      if (m_idx == 2) m_e.seg[7] = 1'b1;
      if (show_new_time && m_phase && blink_mask[m_idx]) m_e.seg = 8'h00;
      m_e.en = ND'(1) << m_idx;
      if (stop_alarm || !alarm_enable)
        m_snd = 1'b0;
      else if (m_hist[$] && !m_hist[$-1])
        m_snd = 1'b1;
      m_hist.push_back(current_time == alarm_time);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      m_e.snd = m_snd;
    end
    exp_q.push_back(m_e);
  end

  exp_t mon_e;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (seg !== mon_e.seg) begin
        errors++;
        $display("FAIL seg t=%0t got %h exp %h", $time, seg, mon_e.seg);
      end
      checks++;
      if (digit_en !== mon_e.en) begin
        errors++;
        $display("FAIL digit_en t=%0t got %b exp %b", $time, digit_en, mon_e.en);
      end
      checks++;
      if (sound !== mon_e.snd) begin
        errors++;
        $display("FAIL sound t=%0t got %b exp %b", $time, sound, mon_e.snd);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    current_time  = 16'h1234;
    alarm_time    = 16'h0700;
    key_time      = 16'h0000;
    show_new_time = 1'b0;
    show_a        = 1'b0;
    blink_mask    = '0;
    alarm_enable  = 1'b0;
    stop_alarm    = 1'b0;
    step(3);
    @(negedge clock); #1 reset = 1'b1;
    step(40);

    key_time = 16'h0859; show_a = 1'b1; show_new_time = 1'b1;
    step(20);
    show_new_time = 1'b0;
    step(20);

    show_a = 1'b0; show_new_time = 1'b1; blink_mask = 4'b0011; key_time = 16'h1234;
    step(80);
    show_new_time = 1'b0; blink_mask = '0;

    alarm_enable = 1'b1; current_time = 16'h0659;
    step(5);
    current_time = 16'h0700;
    step(5);
    current_time = 16'h0701;
    step(5);
    stop_alarm = 1'b1;
    step(1);
    stop_alarm = 1'b0;
    step(5);

    current_time = 16'h0700;
    step(1);
    stop_alarm = 1'b1;
    step(1);
    stop_alarm = 1'b0;
    step(6);

    alarm_enable = 1'b0; current_time = 16'h0659;
    step(3);
    current_time = 16'h0700;
    step(4);
    alarm_enable = 1'b1;
    step(8);

    current_time = 16'h0659;
    step(3);
    current_time = 16'h0700;
    step(4);
    @(negedge clock); #1 reset = 1'b0;
    #1;
    checks++;
    if (sound !== 1'b0 || digit_en !== '0 || seg !== 8'h00) begin
      errors++;
      $display("FAIL async_reset sound=%b digit_en=%b seg=%h exp 0/0/00", sound, digit_en, seg);
    end
    step(2);
    @(negedge clock); #1 reset = 1'b1;
    step(12);

    current_time = 16'hAAAA; alarm_time = 16'h0000;
    step(20);

    for (int i = 0; i < 1500; i++) begin
      if (i % 6 == 0) begin
        current_time  = 16'($urandom);
        alarm_time    = ($urandom_range(0, 2) == 0) ? current_time : 16'($urandom);
        key_time      = 16'($urandom);
        show_new_time = 1'($urandom_range(0, 1));
        show_a        = 1'($urandom_range(0, 1));
        blink_mask    = 4'($urandom);
        alarm_enable  = ($urandom_range(0, 7) != 0);
      end
      stop_alarm = ($urandom_range(0, 15) == 0);
      step(1);
    end
    stop_alarm = 1'b0;
    step(2);
    @(negedge clock); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of BCD digits and scan positions (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is driven (legal ≥2).
REQ-003 SHALL have parameter BLINK_DIV, default 250, scan frames per blink half-period (legal ≥1).
REQ-004 SHALL have port clock, input, 1, single system clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port current_time, input, 4*NUM_DIGITS, current time BCD; digit 0 in bits [3:0] = ls_min.
REQ-007 SHALL have port alarm_time, input, 4*NUM_DIGITS, alarm time BCD, same packing.
REQ-008 SHALL have port key_time, input, 4*NUM_DIGITS, keypad-entered time BCD, same packing.
REQ-009 SHALL have port show_new_time, input, 1, display key_time with blinking.
REQ-010 SHALL have port show_a, input, 1, display alarm_time.
REQ-011 SHALL have port blink_mask, input, NUM_DIGITS, digits subject to blinking.
REQ-012 SHALL have port alarm_enable, input, 1, arms alarm compare.
REQ-013 SHALL have port stop_alarm, input, 1, single-cycle pulse clearing sound.
REQ-014 SHALL have port seg, output, 8, segments {dp,g,f,e,d,c,b,a}, active-high.
REQ-015 SHALL have port digit_en, output, NUM_DIGITS, one-hot digit select, active-high.
REQ-016 SHALL have port sound, output, 1, registered alarm output.

Function
REQ-017 SHALL select source: show_new_time=1 -> key_time; else show_a=1 -> alarm_time; else current_time (show_new_time wins when both set).
REQ-018 SHALL run a scan counter 0..SCAN_DIV-1; at terminal count, advance digit index 0->1->...->NUM_DIGITS-1->0 (wrap).
REQ-019 SHALL register digit_en = one-hot of digit index and seg = encode(selected nibble of index); both update in the same cycle, one clock after the index changes (latency 1).
REQ-020 SHALL encode 0..9 as standard 7-segment (0=0x3F, 1=0x06, ..., 8=0x7F, 9=0x6F); codes 10..15 SHALL give 0x00 (blank).
REQ-021 SHALL drive seg[7] (dp) = 1 only for digit index 2 (hours/minutes separator) when NUM_DIGITS ≥ 3, else 0.
REQ-022 SHALL count scan frames (one frame = index wrap to 0); every BLINK_DIV frames toggle blink_phase.
REQ-023 SHALL, when show_new_time=1 and blink_phase=1 and blink_mask[index]=1, force seg=0x00 while digit_en stays driven.
REQ-024 SHALL keep blink_phase counting regardless of show_new_time; no blanking when show_new_time=0.
REQ-025 SHALL compute match = (current_time == alarm_time) over all NUM_DIGITS digits, registered one cycle.
REQ-026 SHALL set sound on the cycle after a 0->1 transition of registered match while alarm_enable=1.
REQ-027 SHALL clear sound on stop_alarm=1 or alarm_enable=0; clear has priority over set in the same cycle.
REQ-028 SHALL hold sound after match drops (alarm sounds until stopped); re-sets only on a new match rising edge.
REQ-029 SHALL not re-trigger sound from a match already present when alarm_enable rises (edge-only).
REQ-030 SHALL apply source/mode changes at the next seg register update without disturbing the scan counter.

Reset
REQ-031 SHALL, while reset=0, asynchronously force scan counter=0, index=0, frame counter=0, blink_phase=0, match register=1, sound=0, seg=0x00, digit_en=0.
REQ-032 SHALL, after reset release, drive digit_en=one-hot(0) with valid seg on the first clock edge.
REQ-033 SHALL, if reset asserts mid-alarm, drop sound immediately; a match present at release SHALL NOT sound (match register reset to 1).

Structure
REQ-034 SHALL place the 7-segment encoding constants, blank code and dp position in a shared package display_pkg used by all display blocks.
REQ-035 SHALL implement the nibble-to-segment encoder as one combinational sub-module seg7_encode; the scan/blink/alarm logic stays in display_scan_driver.

Verification
REQ-036 SHALL check scanning: NUM_DIGITS=4, SCAN_DIV=4, current_time=0x1234 -> digit_en 0001/0010/0100/1000 each 4 cycles with seg 0x66,0x4F,0xDB(dp),0x06, then wrap.
REQ-037 SHALL check priority: show_a=1, show_new_time=1, key_time=0x0859, alarm_time=0x0700 -> key digits shown; drop show_new_time -> alarm digits.
REQ-038 SHALL check blink: BLINK_DIV=2, show_new_time=1, blink_mask=0011 -> digits 0,1 seg=0x00 in alternate 2-frame windows, digits 2,3 never blank.
REQ-039 SHALL check alarm: alarm_enable=1, alarm_time=0x0700, current_time 0x0659->0x0700 -> sound=1 two cycles later; persists at 0x0701; stop_alarm pulse -> sound=0 next cycle.
REQ-040 SHALL check edge cases: stop_alarm coincident with match edge -> sound stays 0; alarm_enable rising while match=1 -> no sound; reset mid-alarm -> sound=0 asynchronously, no sound after release.
REQ-041 SHALL check code 0xA in a digit -> seg=0x00 (dp still per REQ-021).
